pl_hazard_unit: RTL and testbench

//  Parametrised hazard, forwarding and stall controller for the 5-stage RV32I pipeline.

---
 rtl/pl_hazard_unit_pkg.sv | 14 +
 rtl/pl_hazard_unit_hz_mc_timer.sv | 56 +++++
 rtl/pl_hazard_unit.sv | 140 ++++++++++++++
 tb/tb_pl_hazard_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pl_hazard_unit_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding select
// codes and the multi-cycle EX occupancy FSM states.
package pl_hazard_unit_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef enum logic {
    MC_IDLE = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_e;

endpackage

// File: rtl/pl_hazard_unit_hz_mc_timer.sv
// Multi-cycle EX occupancy timer: IDLE/BUSY FSM with a down-counter.
// BUSY lasts EX_MC_LAT-1 cycles after the start cycle; start is ignored while BUSY.
module hz_mc_timer
  import pl_hazard_unit_pkg::*;
#(
  parameter int unsigned EX_MC_LAT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  output logic busy_o
);

  localparam int unsigned CW    = (EX_MC_LAT > 2) ? $clog2(EX_MC_LAT - 1) : 1;
  localparam bit          MC_EN = (EX_MC_LAT > 1);
  localparam logic [CW-1:0] LOAD = MC_EN ? CW'(EX_MC_LAT - 2) : '0;

  mc_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // State and counter registers, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MC_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: load counter on start, count down while BUSY, leave at zero
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MC_IDLE: begin
        if (start_i && MC_EN) begin
          state_d = MC_BUSY;
          cnt_d   = LOAD;
        end
      end
      MC_BUSY: begin
        if (cnt_q == '0) begin
          state_d = MC_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = MC_IDLE;
    endcase
  end

  assign busy_o = (state_q == MC_BUSY);

endmodule

// File: rtl/pl_hazard_unit.sv
// Hazard, forwarding and stall controller for the 5-stage RV32I pipeline:
// operand forwarding selects, load-use bubbles, redirect flushes, multi-cycle
// EX occupancy and saturating stall/flush performance counters.
module pl_hazard_unit
  import pl_hazard_unit_pkg::*;
#(
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned FWD_EN    = 1,
  parameter int unsigned EX_MC_LAT = 3,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwrite,
  input  logic              ex_redirect,
  input  logic              ex_mc_start,
  output logic              stall_pc,
  output logic              stall_ifid,
  output logic              stall_idex,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic              flush_exmem,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              ex_busy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam bit MC_EN  = (EX_MC_LAT > 1);
  localparam bit FWD_ON = (FWD_EN != 0);

  logic             busy;
  logic             mc_accept;
  logic             redirect_eff;
  logic             ex_hit;
  logic             mem_hit;
  logic             load_use;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                         input logic [REG_AW-1:0] mrd, input logic mrw,
                                         input logic [REG_AW-1:0] wrd, input logic wrw);
    if (mrw && (mrd != '0) && (mrd == rs)) return FWD_MEM;
    if (wrw && (wrd != '0) && (wrd == rs)) return FWD_WB;
    return FWD_RF;
  endfunction

  hz_mc_timer #(
    .EX_MC_LAT(EX_MC_LAT)
  ) u_mc_timer (
    .clk    (clk),
    .reset  (reset),
    .start_i(ex_mc_start),
    .busy_o (busy)
  );

  assign ex_hit  = (ex_rd != '0) &&
                   ((id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd)));
  assign mem_hit = (mem_rd != '0) &&
                   ((id_rs1_used && (id_rs1 == mem_rd)) || (id_rs2_used && (id_rs2 == mem_rd)));

  // Without forwarding any in-flight writer in EX or MEM blocks ID; WB is covered by the write-first RF
  assign load_use = FWD_ON ? (ex_memread && ex_hit)
                           : ((ex_regwrite && ex_hit) || (mem_regwrite && mem_hit));

  assign mc_accept    = ex_mc_start && !busy && MC_EN;
  assign redirect_eff = ex_redirect && !busy && !mc_accept && !reset;

  // Priority: reset quiets everything, then BUSY occupancy, then redirect, then load-use
  always_comb begin
    fwd_a       = FWD_RF;
    fwd_b       = FWD_RF;
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    stall_idex  = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    if (!reset) begin
      if (FWD_ON) begin
        fwd_a = fwd_sel(ex_rs1, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
        fwd_b = fwd_sel(ex_rs2, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
      end
      if (busy) begin
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        stall_idex  = 1'b1;
        flush_exmem = 1'b1;
      end else if (redirect_eff) begin
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
      end else if (load_use) begin
        stall_pc   = 1'b1;
        stall_ifid = 1'b1;
        flush_idex = 1'b1;
      end
    end
  end

  // Saturating next values for the performance counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_pc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (redirect_eff && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // Performance counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ex_busy   = busy;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  // A multi-cycle start colliding with a redirect wins, but the pipeline should never issue both
  a_mc_vs_redirect: assert property (@(posedge clk) disable iff (reset) !(mc_accept && ex_redirect));

endmodule

// File: tb/tb_pl_hazard_unit.sv
// Scoreboard bench for pl_hazard_unit: two instances (forwarding on with an
// 8-bit counter and LAT=3; forwarding off with 16-bit counter and LAT=4)
// share randomized and directed stimulus and are checked against a
// cycle-level reference model.
module tb_pl_hazard_unit;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_rs1_used, id_rs2_used, ex_regwrite, ex_memread;
  logic       mem_regwrite, wb_regwrite, ex_redirect, ex_mc_start;

  logic        a_spc, a_sif, a_sidx, a_fif, a_fidx, a_fexm, a_busy;
  logic [1:0]  a_fa, a_fb;
  logic [7:0]  a_sc, a_fc;
  logic        b_spc, b_sif, b_sidx, b_fif, b_fidx, b_fexm, b_busy;
  logic [1:0]  b_fa, b_fb;
  logic [15:0] b_sc, b_fc;

  pl_hazard_unit #(.REG_AW(5), .FWD_EN(1), .EX_MC_LAT(3), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .ex_redirect(ex_redirect),
    .ex_mc_start(ex_mc_start), .stall_pc(a_spc), .stall_ifid(a_sif),
    .stall_idex(a_sidx), .flush_ifid(a_fif), .flush_idex(a_fidx),
    .flush_exmem(a_fexm), .fwd_a(a_fa), .fwd_b(a_fb), .ex_busy(a_busy),
    .stall_cnt(a_sc), .flush_cnt(a_fc));

  pl_hazard_unit #(.REG_AW(5), .FWD_EN(0), .EX_MC_LAT(4), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .ex_redirect(ex_redirect),
    .ex_mc_start(ex_mc_start), .stall_pc(b_spc), .stall_ifid(b_sif),
    .stall_idex(b_sidx), .flush_ifid(b_fif), .flush_idex(b_fidx),
    .flush_exmem(b_fexm), .fwd_a(b_fa), .fwd_b(b_fb), .ex_busy(b_busy),
    .stall_cnt(b_sc), .flush_cnt(b_fc));

  typedef struct {
    logic [1:0]  fa, fb;
    logic        spc, sif, sidx, fif, fidx, fexm, busy;
    int unsigned sc, fc;
  } exp_t;

  exp_t        q0[$], q1[$];
  int unsigned n_chk = 0, n_fail = 0;

  // Reference model state: remaining busy cycles and counter values per instance
  int unsigned rem[2], scnt[2], fcnt[2];

  function automatic int unsigned lat_of(int i);   return (i == 0) ? 3 : 4;         endfunction
  function automatic bit          fen_of(int i);   return (i == 0);                 endfunction
  function automatic int unsigned cmax_of(int i);  return (i == 0) ? 255 : 65535;   endfunction

  function automatic bit id_reads(logic [4:0] r);
    return (r != 0) && ((id_rs1_used && id_rs1 == r) || (id_rs2_used && id_rs2 == r));
  endfunction

  function automatic logic [1:0] fwd_of(int i, logic [4:0] rs);
    if (!fen_of(i)) return 2'b00;
    if (mem_regwrite && mem_rd != 0 && mem_rd == rs) return 2'b10;
    if (wb_regwrite && wb_rd != 0 && wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t model_out(int i);
    exp_t e;
    bit busy, accept, redir, hz;
    busy = (rem[i] > 0);
    e = '{fa: 2'b00, fb: 2'b00, spc: 0, sif: 0, sidx: 0, fif: 0, fidx: 0, fexm: 0,
          busy: busy, sc: scnt[i], fc: fcnt[i]};
    if (!reset) begin
      e.fa   = fwd_of(i, ex_rs1);
      e.fb   = fwd_of(i, ex_rs2);
      accept = ex_mc_start && !busy && lat_of(i) > 1;
      redir  = ex_redirect && !busy && !accept;
      if (fen_of(i)) hz = ex_memread && id_reads(ex_rd);
      else           hz = (ex_regwrite && id_reads(ex_rd)) || (mem_regwrite && id_reads(mem_rd));
      if (busy) begin
        e.spc = 1; e.sif = 1; e.sidx = 1; e.fexm = 1;
      end else if (redir) begin
        e.fif = 1; e.fidx = 1;
      end else if (hz) begin
        e.spc = 1; e.sif = 1; e.fidx = 1;
      end
    end
    return e;
  endfunction

  task automatic model_advance(int i, exp_t e);
    if (reset) begin
      rem[i] = 0; scnt[i] = 0; fcnt[i] = 0;
    end else begin
      if (rem[i] > 0) rem[i]--;
      else if (ex_mc_start && lat_of(i) > 1) rem[i] = lat_of(i) - 1;
      if (e.spc && scnt[i] < cmax_of(i)) scnt[i]++;
      if (e.fif && fcnt[i] < cmax_of(i)) fcnt[i]++;
    end
  endtask

  task automatic clr();
    reset = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_regwrite = 0; ex_memread = 0;
    mem_rd = 0; mem_regwrite = 0; wb_rd = 0; wb_regwrite = 0;
    ex_redirect = 0; ex_mc_start = 0;
  endtask

  // Issue the current input vector for one cycle and queue its expected response
  task automatic step();
    exp_t e0, e1;
    e0 = model_out(0);
    e1 = model_out(1);
    q0.push_back(e0);
    q1.push_back(e1);
    model_advance(0, e0);
    model_advance(1, e1);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, int unsigned act, int unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: each cycle the DUTs present a response, pop and compare it
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("a.fwd_a", a_fa, e.fa);           chk("a.fwd_b", a_fb, e.fb);
        chk("a.stall_pc", a_spc, e.spc);      chk("a.stall_ifid", a_sif, e.sif);
        chk("a.stall_idex", a_sidx, e.sidx);  chk("a.flush_ifid", a_fif, e.fif);
        chk("a.flush_idex", a_fidx, e.fidx);  chk("a.flush_exmem", a_fexm, e.fexm);
        chk("a.ex_busy", a_busy, e.busy);     chk("a.stall_cnt", a_sc, e.sc);
        chk("a.flush_cnt", a_fc, e.fc);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("b.fwd_a", b_fa, e.fa);           chk("b.fwd_b", b_fb, e.fb);
        chk("b.stall_pc", b_spc, e.spc);      chk("b.stall_ifid", b_sif, e.sif);
        chk("b.stall_idex", b_sidx, e.sidx);  chk("b.flush_ifid", b_fif, e.fif);
        chk("b.flush_idex", b_fidx, e.fidx);  chk("b.flush_exmem", b_fexm, e.fexm);
        chk("b.ex_busy", b_busy, e.busy);     chk("b.stall_cnt", b_sc, e.sc);
        chk("b.flush_cnt", b_fc, e.fc);
      end
    end
  end

  initial begin
    clr();
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin rem[i] = 0; scnt[i] = 0; fcnt[i] = 0; end

    // Reset held: outputs quiet, counters zero
    reset = 1; step();
    clr(); step();

    // lw x5,0(x0); add x6,x5,x1: stall, bubble, then WB forward
    clr(); ex_rd = 5; ex_regwrite = 1; ex_memread = 1;
    id_rs1 = 5; id_rs2 = 1; id_rs1_used = 1; id_rs2_used = 1; step();
    clr(); mem_rd = 5; mem_regwrite = 1;
    id_rs1 = 5; id_rs2 = 1; id_rs1_used = 1; id_rs2_used = 1; step();
    clr(); ex_rs1 = 5; ex_rs2 = 1; ex_rd = 6; ex_regwrite = 1; wb_rd = 5; wb_regwrite = 1; step();

    // add x5; sub x7,x5,x5 back-to-back
    clr(); ex_rs1 = 5; ex_rs2 = 5; mem_rd = 5; mem_regwrite = 1; step();
    // MEM and WB both write x5: MEM wins
    clr(); ex_rs1 = 5; ex_rs2 = 3; mem_rd = 5; mem_regwrite = 1; wb_rd = 5; wb_regwrite = 1; step();
    // Writes to x0 are never forwarded and never stall
    clr(); ex_rd = 0; ex_memread = 1; ex_regwrite = 1; id_rs1 = 0; id_rs1_used = 1;
    mem_rd = 0; mem_regwrite = 1; wb_rd = 0; wb_regwrite = 1; step();
    // Unused source does not stall
    clr(); ex_rd = 5; ex_memread = 1; ex_regwrite = 1; id_rs2 = 5; step();
    // Taken branch while a load-use match is present
    clr(); ex_rd = 5; ex_memread = 1; ex_regwrite = 1; id_rs1 = 5; id_rs1_used = 1;
    ex_redirect = 1; step();
    // FWD_EN=0: add x5 then add x6,x5,x0 stalls while x5 is in EX and MEM
    clr(); ex_rd = 5; ex_regwrite = 1; id_rs1 = 5; id_rs1_used = 1; id_rs2_used = 1; step();
    clr(); mem_rd = 5; mem_regwrite = 1; id_rs1 = 5; id_rs1_used = 1; id_rs2_used = 1; step();
    clr(); wb_rd = 5; wb_regwrite = 1; id_rs1 = 5; id_rs1_used = 1; id_rs2_used = 1; step();

    // Multi-cycle op, then repeat start while busy (ignored)
    clr(); ex_mc_start = 1; step();
    clr(); ex_mc_start = 1; ex_rd = 5; ex_memread = 1; id_rs1 = 5; id_rs1_used = 1; step();
    clr(); ex_redirect = 1; step();
    clr(); repeat (3) step();
    // Reset during the first busy cycle
    clr(); ex_mc_start = 1; step();
    clr(); reset = 1; step();
    clr(); repeat (2) step();

    // Randomized traffic with occasional resets
    for (int n = 0; n < 1500; n++) begin
      clr();
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
      ex_rd  = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
      wb_rd  = 5'($urandom_range(0, 3));
      id_rs1_used = 1'($urandom_range(0, 1)); id_rs2_used = 1'($urandom_range(0, 1));
      ex_regwrite = 1'($urandom_range(0, 1)); ex_memread  = 1'($urandom_range(0, 1));
      mem_regwrite = 1'($urandom_range(0, 1)); wb_regwrite = 1'($urandom_range(0, 1));
      ex_mc_start = ($urandom_range(0, 9) == 0);
      ex_redirect = !ex_mc_start && ($urandom_range(0, 7) == 0);
      reset       = ($urandom_range(0, 199) == 0);
      step();
    end

    // Saturation: 2^8+3 consecutive stall cycles on the 8-bit instance
    clr(); reset = 1; step();
    clr(); ex_rd = 5; ex_memread = 1; ex_regwrite = 1; id_rs1 = 5; id_rs1_used = 1;
    repeat (259) step();
    clr(); repeat (2) step();

    @(negedge clk);
    @(negedge clk);
    chk("queue_a_drained", q0.size(), 0);
    chk("queue_b_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
